dzielnik_programowalny: RTL and testbench
=========================================

Name: dzielnik_programowalny

Overview:
Runtime-programmable clock divider and SCLK generator. Parametrised successor of the fixed 1 Hz divider.
- Produces a divided clock with programmable half-period and selectable idle polarity (CPOL).
- Produces one-cycle rise/fall strobes aligned to the divided-clock edges.
- Two modes: free-running (visible blink/timebase) and burst (N clock cycles for the SPI master shift engine, with a done pulse).

Parameters:
CNT_W, 16, width of the half-period counter and of in_half_period.
CYC_W, 8, width of the burst cycle count in_cycles.

Ports:
in_clock  input  1  system clock; all logic on rising edge.
in_reset_n  input  1  asynchronous active-low reset.
in_half_period  input  CNT_W  in_clock cycles per half period of out_clock; value 0 treated as 1.
in_mode  input  1  0 = free-run, 1 = burst; sampled only in IDLE.
in_enable  input  1  free-run enable (level).
in_start  input  1  burst start request, single-cycle; sampled only in IDLE with in_mode=1.
in_cycles  input  CYC_W  number of full out_clock cycles (2*in_cycles edges) per burst.
in_cpol  input  1  idle level of out_clock.
out_clock  output  1  divided clock, registered.
out_rise  output  1  one-cycle strobe, high in the cycle out_clock has just become 1.
out_fall  output  1  one-cycle strobe, high in the cycle out_clock has just become 0.
out_busy  output  1  high while in FREE or BURST.
out_done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (async, in_reset_n=0): state IDLE, counter=0, cycle counter=0.
- Reset output values: out_clock=0, out_rise=0, out_fall=0, out_busy=0, out_done=0.
- Reset mid-burst aborts immediately; no out_done is issued.
- States: IDLE, FREE, BURST.
- IDLE:
  - out_clock <= in_cpol every cycle, with no strobes.
  - counter held at 0.
  - in_mode=0 and in_enable=1 -> FREE; H is latched.
  - in_mode=1 and in_start=1 and in_cycles!=0 -> BURST; H and edges_left=2*in_cycles are latched.
  - in_mode=1 and in_start=1 and in_cycles=0 -> stay IDLE; out_done=1 on the next cycle.
- Counting (FREE and BURST), with H = max(in_half_period,1):
  - Counter runs 0..H-1.
  - At count H-1: counter <= 0 and out_clock toggles.
  - The matching strobe asserts in the same registered cycle as the out_clock change.
  - First toggle occurs exactly H in_clock cycles after the edge that sampled the start/enable.
  - out_busy is high from the cycle after that sampling edge.
- FREE:
  - H is re-sampled at every toggle; a change takes effect from the next half-period. No glitches or short half-periods.
  - in_enable=0 with out_clock==in_cpol -> IDLE next cycle.
  - in_enable=0 with out_clock!=in_cpol -> finish the current half-period, toggle back to cpol (strobe issued), then go to IDLE.
- BURST:
  - H, cpol and edges_left are frozen for the whole burst.
  - edges_left decrements on each toggle.
  - The toggle that makes edges_left 0 returns out_clock to cpol. On that same edge the state goes to IDLE, out_busy=0 and out_done=1 for one cycle.
  - in_start, in_mode and in_cycles are ignored while busy.
- Strobe polarity:
  - CPOL=0: first burst edge is a rise.
  - CPOL=1: first burst edge is a fall.
- out_rise and out_fall are never high in the same cycle.
- At H=1, out_clock = in_clock/2 and exactly one strobe is high every cycle.
- Widths:
  - Counter is CNT_W bits; maximum half-period is 2^CNT_W-1.
  - edges_left is CYC_W+1 bits; in_cycles=2^CYC_W-1 is supported.
- IDLE out_clock must follow a change of in_cpol within 1 cycle.

Test Plan:
- Reset then free-run: in_reset_n low then high, in_cpol=0, in_mode=0, in_enable=1, in_half_period=3 -> out_clock period 6 cycles; first rise 3 cycles after enable is sampled; out_rise/out_fall alternate every 3 cycles.
- Burst CPOL=0: in_half_period=2, in_cycles=8, in_start pulse -> exactly 8 rises and 8 falls; out_busy high for 32 cycles; out_done pulse coincident with the final fall; out_clock ends at 0.
- Burst CPOL=1 and H=0: in_half_period=0, in_cycles=3 -> treated as H=1; first edge is a fall; 6 strobes on consecutive cycles; out_clock ends at 1; out_done after 6 cycles.
- Free-run stop and retune: enable with H=4; change to H=2 mid-half-period -> current half stays 4 cycles, the next ones are 2. Drop in_enable while out_clock=1 -> one more fall with strobe, then IDLE and out_busy=0.
- Edge cases: in_start with in_cycles=0 -> out_done only, no edges, out_busy stays 0. in_start asserted again mid-burst -> ignored, edge count unchanged.
- Async reset mid-burst (in_cycles=4, after 3 edges) -> all outputs 0 immediately with no out_done; a new burst after release behaves as normal.

Source files
------------

// File: rtl/dzielnik_programowalny.sv
// Runtime-programmable clock divider / SCLK generator with free-run and burst modes.
// Produces a registered divided clock plus aligned rise/fall strobes and a burst-done pulse.
module dzielnik_programowalny #(
    parameter int CNT_W = 16,
    parameter int CYC_W = 8
) (
    input  logic             in_clock,
    input  logic             in_reset_n,
    input  logic [CNT_W-1:0] in_half_period,
    input  logic             in_mode,
    input  logic             in_enable,
    input  logic             in_start,
    input  logic [CYC_W-1:0] in_cycles,
    input  logic             in_cpol,
    output logic             out_clock,
    output logic             out_rise,
    output logic             out_fall,
    output logic             out_busy,
    output logic             out_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FREE  = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   half_q, half_d;
    logic [CYC_W:0]     edges_q, edges_d;
    logic               cpol_q, cpol_d;
    logic               clk_q, clk_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]   half_in;
    logic               last_cnt;

    // A programmed half-period of 0 behaves exactly like 1.
    assign half_in  = (in_half_period == '0) ? CNT_W'(1) : in_half_period;
    assign last_cnt = (cnt_q == half_q - CNT_W'(1));

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        edges_d = edges_q;
        cpol_d  = cpol_q;
        clk_d   = clk_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                clk_d  = in_cpol;
                cpol_d = in_cpol;
                if (!in_mode && in_enable) begin
                    state_d = ST_FREE;
                    half_d  = half_in;
                end else if (in_mode && in_start) begin
                    if (in_cycles != '0) begin
                        state_d = ST_BURST;
                        half_d  = half_in;
                        edges_d = {in_cycles, 1'b0};
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            ST_FREE: begin
                // Stopping only happens at the idle level, so the last half-period is never cut short.
                if (!in_enable && (clk_q == in_cpol)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    clk_d   = in_cpol;
                end else if (last_cnt) begin
                    cnt_d  = '0;
                    clk_d  = ~clk_q;
                    rise_d = ~clk_q;
                    fall_d = clk_q;
                    half_d = half_in;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_BURST: begin
                if (last_cnt) begin
                    cnt_d   = '0;
                    clk_d   = ~clk_q;
                    rise_d  = ~clk_q;
                    fall_d  = clk_q;
                    edges_d = edges_q - (CYC_W+1)'(1);
                    if (edges_q == (CYC_W+1)'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            half_q  <= CNT_W'(1);
            edges_q <= '0;
            cpol_q  <= 1'b0;
            clk_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            edges_q <= edges_d;
            cpol_q  <= cpol_d;
            clk_q   <= clk_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_clock = clk_q;
    assign out_rise  = rise_q;
    assign out_fall  = fall_q;
    assign out_busy  = busy_q;
    assign out_done  = done_q;

endmodule

// File: tb/tb_dzielnik_programowalny.sv
// Directed self-checking bench for dzielnik_programowalny: free-run, bursts, retune, stop and reset abort.
module tb_dzielnik_programowalny;

    logic        in_clock = 1'b0;
    logic        in_reset_n;
    logic [15:0] in_half_period;
    logic        in_mode;
    logic        in_enable;
    logic        in_start;
    logic [7:0]  in_cycles;
    logic        in_cpol;
    logic        out_clock;
    logic        out_rise;
    logic        out_fall;
    logic        out_busy;
    logic        out_done;

    int n_checks = 0;
    int n_errors = 0;

    dzielnik_programowalny #(.CNT_W(16), .CYC_W(8)) dut (
        .in_clock       (in_clock),
        .in_reset_n     (in_reset_n),
        .in_half_period (in_half_period),
        .in_mode        (in_mode),
        .in_enable      (in_enable),
        .in_start       (in_start),
        .in_cycles      (in_cycles),
        .in_cpol        (in_cpol),
        .out_clock      (out_clock),
        .out_rise       (out_rise),
        .out_fall       (out_fall),
        .out_busy       (out_busy),
        .out_done       (out_done)
    );

    always #5 in_clock = ~in_clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge in_clock);
        #1;
    endtask

    initial begin
        int rises, falls, busy_cnt, done_cnt, done_at, overlap, strobes, first_k, last_k;
        logic done_with_fall, first_is_rise;

        in_reset_n     = 1'b0;
        in_half_period = 16'd3;
        in_mode        = 1'b0;
        in_enable      = 1'b0;
        in_start       = 1'b0;
        in_cycles      = 8'd0;
        in_cpol        = 1'b0;
        tick();
        tick();
        check("reset clock", out_clock, 0);
        check("reset rise",  out_rise,  0);
        check("reset fall",  out_fall,  0);
        check("reset busy",  out_busy,  0);
        check("reset done",  out_done,  0);

        // Free-run H=3: toggles every 3 cycles after the enable-sampling edge.
        in_reset_n = 1'b1;
        in_enable  = 1'b1;
        tick();
        check("free start busy",  out_busy,  1);
        check("free start clock", out_clock, 0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("free k=%0d clock", k), out_clock, (k / 3) % 2);
            check($sformatf("free k=%0d rise", k),  out_rise,  (k % 3 == 0) && ((k / 3) % 2 == 1));
            check($sformatf("free k=%0d fall", k),  out_fall,  (k % 3 == 0) && ((k / 3) % 2 == 0));
        end
        in_enable = 1'b0;
        tick();
        check("free stop busy",  out_busy,  0);
        check("free stop clock", out_clock, 0);

        // Burst CPOL=0, H=2, 8 cycles; a second start mid-burst must be ignored.
        in_half_period = 16'd2;
        in_mode        = 1'b1;
        in_cycles      = 8'd8;
        in_start       = 1'b1;
        tick();
        in_start = 1'b0;
        rises = 0; falls = 0; busy_cnt = 0; done_cnt = 0; done_at = 0; overlap = 0; first_k = 0;
        done_with_fall = 1'b0; first_is_rise = 1'b0;
        if (out_busy) busy_cnt++;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) begin
                in_start  = 1'b1;
                in_cycles = 8'd1;
            end else begin
                in_start = 1'b0;
            end
            tick();
            if (out_rise) rises++;
            if (out_fall) falls++;
            if (out_rise && out_fall) overlap++;
            if (out_busy) busy_cnt++;
            if (first_k == 0 && (out_rise || out_fall)) begin
                first_k       = k;
                first_is_rise = out_rise;
            end
            if (out_done) begin
                done_cnt++;
                done_at        = k;
                done_with_fall = out_fall;
            end
        end
        check("burst0 rises",        rises,          8);
        check("burst0 falls",        falls,          8);
        check("burst0 busy cycles",  busy_cnt,       32);
        check("burst0 done count",   done_cnt,       1);
        check("burst0 done cycle",   done_at,        32);
        check("burst0 done w/ fall", done_with_fall, 1);
        check("burst0 overlap",      overlap,        0);
        check("burst0 first edge k", first_k,        2);
        check("burst0 first rise",   first_is_rise,  1);
        check("burst0 end clock",    out_clock,      0);

        // Idle clock follows CPOL within one cycle.
        in_cpol = 1'b1;
        tick();
        check("idle cpol follow", out_clock, 1);

        // Burst CPOL=1, H=0 (acts as 1), 3 cycles: six consecutive strobes, first is a fall.
        in_half_period = 16'd0;
        in_cycles      = 8'd3;
        in_start       = 1'b1;
        tick();
        in_start = 1'b0;
        check("burst1 start busy", out_busy, 1);
        strobes = 0; first_k = 0; last_k = 0; done_at = 0; overlap = 0; first_is_rise = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (out_rise || out_fall) begin
                strobes++;
                last_k = k;
                if (first_k == 0) begin
                    first_k       = k;
                    first_is_rise = out_rise;
                end
            end
            if (out_rise && out_fall) overlap++;
            if (out_done) done_at = k;
        end
        check("burst1 strobes",     strobes,       6);
        check("burst1 first k",     first_k,       1);
        check("burst1 last k",      last_k,        6);
        check("burst1 first fall",  first_is_rise, 0);
        check("burst1 done cycle",  done_at,       6);
        check("burst1 overlap",     overlap,       0);
        check("burst1 end clock",   out_clock,     1);
        check("burst1 end busy",    out_busy,      0);

        // Free-run retune H=4 -> 2 mid-half-period, then stop while out_clock is high.
        in_cpol        = 1'b0;
        in_mode        = 1'b0;
        in_enable      = 1'b1;
        in_half_period = 16'd4;
        tick();
        check("retune start clock", out_clock, 0);
        for (int k = 1; k <= 14; k++) begin
            tick();
            check($sformatf("retune k=%0d rise", k), out_rise, (k == 4) || (k == 10));
            check($sformatf("retune k=%0d fall", k), out_fall, (k == 8) || (k == 12));
            check($sformatf("retune k=%0d busy", k), out_busy, k < 13);
            if (k == 5)  in_half_period = 16'd2;
            if (k == 10) in_enable = 1'b0;
        end
        check("retune end clock", out_clock, 0);

        // Zero-cycle burst request: done pulse only.
        in_mode   = 1'b1;
        in_cycles = 8'd0;
        in_start  = 1'b1;
        tick();
        in_start = 1'b0;
        check("zero done",  out_done, 1);
        check("zero busy",  out_busy, 0);
        strobes = 0; busy_cnt = 0; done_cnt = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (out_rise || out_fall) strobes++;
            if (out_busy) busy_cnt++;
            if (out_done) done_cnt++;
        end
        check("zero strobes", strobes,  0);
        check("zero busy cnt", busy_cnt, 0);
        check("zero done once", done_cnt, 0);

        // Async reset mid-burst after three edges aborts with no done.
        in_half_period = 16'd2;
        in_cycles      = 8'd4;
        in_start       = 1'b1;
        tick();
        in_start = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        check("abort pre clock", out_clock, 1);
        #2 in_reset_n = 1'b0;
        #1;
        check("abort clock", out_clock, 0);
        check("abort busy",  out_busy,  0);
        check("abort rise",  out_rise,  0);
        check("abort done",  out_done,  0);
        done_cnt = 0;
        for (int k = 1; k <= 2; k++) begin
            tick();
            if (out_done) done_cnt++;
        end
        check("abort no done", done_cnt, 0);

        // New burst after release: H=1, one cycle.
        in_reset_n     = 1'b1;
        in_half_period = 16'd1;
        in_cycles      = 8'd1;
        in_start       = 1'b1;
        tick();
        in_start = 1'b0;
        check("post t0 busy", out_busy, 1);
        tick();
        check("post t1 rise",  out_rise,  1);
        check("post t1 clock", out_clock, 1);
        check("post t1 done",  out_done,  0);
        tick();
        check("post t2 fall",  out_fall,  1);
        check("post t2 done",  out_done,  1);
        check("post t2 busy",  out_busy,  0);
        check("post t2 clock", out_clock, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
